// File: rtl/clock_enable_scheduler_pkg.sv
// Shared definitions for the clock-enable scheduler: state encoding and parameter checks.
package clock_enable_scheduler_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StOff  = 2'd0,
    StWarm = 2'd1,
    StOn   = 2'd2,
    StCool = 2'd3
  } state_e;

  localparam int unsigned NreqMin  = 2;
  localparam int unsigned NreqMax  = 8;
  localparam int unsigned DelayMin = 1;
  localparam int unsigned DelayMax = 255;

  function automatic bit params_ok(input int unsigned nreq, input int unsigned warmup,
                                   input int unsigned idle, input int unsigned cnt_w);
    int unsigned max_load;
    max_load = ((warmup > idle) ? warmup : idle) - 1;
    return (nreq >= NreqMin) && (nreq <= NreqMax) &&
           (warmup >= DelayMin) && (warmup <= DelayMax) &&
           (idle >= DelayMin) && (idle <= DelayMax) &&
           (cnt_w >= 1) && (cnt_w <= 31) && (max_load < (32'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/clock_enable_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, with wrap-around.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic            valid_o
);

  logic [PtrW-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % NREQ);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Clock-enable scheduler: OFF/WARM/ON/COOL control of a gated clock region with a
// round-robin, hold-while-requested grant among NREQ requesters.
module clock_enable_scheduler
  import clock_enable_scheduler_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned WARMUP       = 4,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic              force_on,
  output logic              ce,
  output logic              ready,
  output logic [NREQ-1:0]   gnt,
  output logic [StateW-1:0] state_o
);

  localparam int unsigned PtrW     = $clog2(NREQ);
  localparam logic [CNT_W-1:0] WarmLoad = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] IdleLoad = CNT_W'(IDLE_TIMEOUT - 1);

  if (!params_ok(NREQ, WARMUP, IDLE_TIMEOUT, CNT_W)) begin : gen_bad_params
    $error("clock_enable_scheduler: parameter out of range");
  end

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PtrW-1:0] ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic            ce_q;
  logic            ready_q;

  logic            act;
  logic [NREQ-1:0] winner;
  logic            win_valid;
  logic [PtrW-1:0] win_idx;
  logic [PtrW-1:0] next_ptr;

  assign act = (|req) | force_on;

  rr_arbiter #(
    .NREQ(NREQ),
    .PtrW(PtrW)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .winner_o(winner),
    .valid_o (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = PtrW'(i);
    end
    next_ptr = (win_idx == PtrW'(NREQ - 1)) ? '0 : win_idx + PtrW'(1);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= StOff;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ce_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (act) begin
            state_q <= StWarm;
            cnt_q   <= WarmLoad;
            ce_q    <= 1'b1;
          end
        end
        StWarm: begin
          if (cnt_q == '0) begin
            state_q <= StOn;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StOn: begin
          if (gnt_q != '0) begin
            // Holder released: hand over on the same edge, holder's bit is already low.
            if ((gnt_q & req) == '0) begin
              gnt_q <= winner;
              if (win_valid) ptr_q <= next_ptr;
            end
          end else if (win_valid) begin
            gnt_q <= winner;
            ptr_q <= next_ptr;
          end else if (!act) begin
            state_q <= StCool;
            cnt_q   <= IdleLoad;
            ready_q <= 1'b0;
          end
        end
        StCool: begin
          if (act) begin
            state_q <= StOn;
            ready_q <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= StOff;
            ce_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= StOff;
          ce_q    <= 1'b0;
          ready_q <= 1'b0;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign ce      = ce_q;
  assign ready   = ready_q;
  assign gnt     = gnt_q;
  assign state_o = state_q;

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Controls the clock-enable of a buffered clock region, so the region's clock runs only when it is needed.
- Shares that region between NREQ requesters through a round-robin, grant-held-while-requested arbiter.
- Applies a warm-up interval after the enable is raised and an idle cool-down before the enable is dropped.
- Sits between the global clock buffer and the datapath blocks that use the gated region.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WARMUP, 4, cycles from ce rising to ready (1..255)
- IDLE_TIMEOUT, 16, idle cycles spent in COOL before ce falls (1..255)
- CNT_W, 8, width of the internal down-counter; must hold max(WARMUP, IDLE_TIMEOUT)-1

Ports:
- clk_in  input  1  system clock, rising-edge; the only clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request; level, held until done
- force_on  input  1  keeps the region enabled with no requester (debug/test)
- ce  output  1  clock-enable to the gated region; registered
- ready  output  1  high while the region is usable (state ON); registered
- gnt  output  NREQ  one-hot grant, or all zero; registered
- state_o  output  2  current state: OFF=0, WARM=1, ON=2, COOL=3

Behaviour:
- Reset (asynchronous, active-high):
  - state=OFF, ce=0, ready=0, gnt=0, counter=0.
  - Round-robin pointer set so req[0] has highest priority.
  - Reset asserted at any point returns all outputs to these values immediately; any active grant is lost.
- Let act = |req | force_on.
- OFF:
  - ce=0, gnt=0.
  - act=1 -> WARM; ce=1 next cycle; counter loads WARMUP-1.
- WARM:
  - ce=1, ready=0, gnt=0.
  - Counter decrements each cycle.
  - At counter==0 -> ON, regardless of act.
  - WARMUP=1 gives exactly one WARM cycle.
- ON:
  - ce=1, ready=1.
  - If no grant is held and req!=0: the round-robin winner is granted on the next edge.
  - Winner = first set req at or after the pointer, in increasing index order with wrap-around.
  - A grant is held while its req is high. The pointer is updated to winner+1 (mod NREQ) when the grant is issued.
  - The holder's req sampled low: gnt drops on the next edge, and a new winner (if any) is granted on that same edge. No gap cycle.
  - gnt never asserts for a requester whose req is low in the sampled cycle.
  - act=0 and no grant held -> COOL; counter loads IDLE_TIMEOUT-1.
- COOL:
  - ce=1, ready=0, gnt=0.
  - act=1 -> ON on the next edge, with no warm-up; the grant follows per ON rules one cycle later.
  - Counter==0 with act=0 -> OFF; ce=0 on that edge.
  - When act=1 and counter==0 occur in the same cycle, act wins -> ON.
- force_on:
  - Prevents entry to COOL.
  - Does not produce grants.
  - Dropping it with no requests starts the normal cool-down.
- Latency from first req in OFF to gnt: 1 (to WARM) + WARMUP + 1 cycles.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Loaded only on state entry.
  - Never decrements below 0.
- Outputs are glitch-free (all registered).
- The block contains no clock gating cell; ce feeds the region's enable/BUFGCE.

Decomposition:
- Shared package holds:
  - state encoding localparams (OFF/WARM/ON/COOL)
  - state width
  - parameter range checks as constants
- One sub-module, rr_arbiter:
  - Inputs: NREQ, req, pointer.
  - Outputs: one-hot winner and valid.
  - Purely combinational.
- The FSM, counter, pointer and grant registers stay in clock_enable_scheduler.

Test Plan:
1. Reset release, all inputs 0 for 50 cycles -> state_o=0, ce=0, gnt=0 throughout; reset pulsed mid-ON -> outputs zero immediately.
2. Defaults, req=4'b0001 at cycle 0 -> ce=1 at cycle 1, ready=1 at cycle 5, gnt=4'b0001 at cycle 6; drop req -> gnt=0 next cycle, COOL for 16 cycles, then ce=0.
3. In ON, req=4'b1011 held, each holder drops its req after 3 granted cycles -> grant order 0,1,3,0 with no gap cycles; gnt is always one-hot.
4. In COOL at counter=5, req[2] rises -> ON on the next edge, gnt=4'b0100 one cycle later, no WARM visited.
5. force_on=1 alone -> WARM, then ON with gnt=0; stays ON indefinitely; force_on=0 -> COOL, then OFF after 16 cycles.
6. req[1] pulses for 1 cycle during WARM and drops -> ON is still reached, no grant issued, then COOL, then OFF; state_o sequence 0,1,2,3,0.
